layer_sched: RTL and testbench
==============================

// Module: layer_sched
// PURPOSE
//  Network-level sequencer for the CNN accelerator. Holds a small layer program
//  (CONV/POOL/FC/END per entry) and runs it on start. For each layer it launches
//  one engine controller (conv/pool/fc), steers the shared DRAM port to that
//  engine, waits for the engine's done, and ping-pongs the feature-map banks.
//  A watchdog catches hung engines, and spurious done pulses are flagged as errors.
// PARAMETERS
//  NUM_LAYERS      8         program table depth (entries 0..NUM_LAYERS-1)
//  IDX_W           3         width of layer index (= log2 NUM_LAYERS)
//  ADDR_WIDTH      18        DRAM address width
//  BANK_A          18'd65536 feature-map bank A base
//  BANK_B          18'd131072 feature-map bank B base
//  TIMEOUT_W       20        watchdog counter width
//  TIMEOUT_CYCLES  20'd1000000 max WAIT cycles before timeout error
// PORTS
//  clk          in   1          clock
//  srstn        in   1          synchronous active-low reset
//  start        in   1          begin program (sampled in IDLE/ERROR)
//  abort        in   1          force return to IDLE
//  cfg_we       in   1          program-table write strobe
//  cfg_idx      in   IDX_W      table entry to write
//  cfg_type     in   2          00 CONV, 01 POOL, 10 FC, 11 END
//  conv_done    in   1          done pulse from conv engine
//  pool_done    in   1          done pulse from pool engine
//  fc_done      in   1          done pulse from fc engine
//  en_conv      out  1          one-cycle launch pulse to conv engine
//  en_pool      out  1          one-cycle launch pulse to pool engine
//  en_fc        out  1          one-cycle launch pulse to fc engine
//  eng_sel      out  2          DRAM port mux select: 0 conv, 1 pool, 2 fc, 3 none
//  ifmap_base   out  ADDR_WIDTH input feature-map base for current layer
//  ofmap_base   out  ADDR_WIDTH output feature-map base for current layer
//  cur_layer    out  IDX_W      index of layer being run
//  busy         out  1          high in every state except IDLE and ERROR
//  done         out  1          one-cycle pulse at program completion
//  err          out  1          sticky error flag
//  err_code     out  2          0 none, 1 timeout, 2 spurious done
// BEHAVIOUR
//  Reset: state IDLE; all table entries END; outputs 0, except eng_sel=3 and bank=0.
//  - Reset outputs: ifmap_base=BANK_A, ofmap_base=BANK_B.
//  States: IDLE, FETCH, LAUNCH, WAIT, NEXT, FINISH, ERROR (one-hot).
//  cfg_we: writes table[cfg_idx]<=cfg_type only while busy=0.
//  - A write with busy=1 is dropped.
//  IDLE/ERROR + start: cur_layer<=0, bank<=0, err<=0, err_code<=0, go to FETCH.
//  FETCH: if table[cur_layer]==END go to FINISH, else go to LAUNCH.
//  LAUNCH: eng_sel<=type (registered); watchdog<=0; go to WAIT.
//  - The matching en_* is high only in the first WAIT cycle; all en_* are registered.
//  WAIT: watchdog counts up by 1 each cycle.
//  - Done from the selected engine: go to NEXT.
//  - Done from a non-selected engine: ERROR with err_code=2.
//  - No done by watchdog==TIMEOUT_CYCLES-1: ERROR with err_code=1.
//  - Valid done and timeout in the same cycle: done wins.
//  - Valid done and spurious done in the same cycle: error wins.
//  - A done in the en_* cycle itself is accepted.
//  NEXT: bank<=~bank; eng_sel<=3.
//  - If cur_layer==NUM_LAYERS-1 go to FINISH (no wrap).
//  - Otherwise cur_layer<=cur_layer+1 and go to FETCH.
//  FINISH: done=1 for exactly one cycle; go to IDLE.
//  ERROR: err=1, err_code held, eng_sel=3, busy=0; stays until start or abort.
//  abort (any state): IDLE next cycle.
//  - Clears en_* and err; eng_sel=3; no done pulse; table preserved.
//  - abort has priority over start and over all done inputs.
//  Bank mapping:
//  - bank=0: ifmap_base=BANK_A, ofmap_base=BANK_B.
//  - bank=1: the two bases are swapped.
//  Done inputs in IDLE, FETCH, LAUNCH, NEXT or FINISH are ignored.
//  Watchdog saturates; it never wraps.
// TESTING
//  1. Program CONV,POOL,FC,END; start; each done 10 cycles after its en_*.
//     -> en_conv, en_pool, en_fc pulse once each in order; eng_sel 0,1,2;
//        ifmap_base A,B,A; one done; busy=0.
//  2. Table all END; start -> done 2 cycles later; no en_* pulses; bank stays 0.
//  3. TIMEOUT_CYCLES=16; CONV layer; conv_done never asserted.
//     -> err=1, err_code=1 after 16 WAIT cycles; eng_sel=3; busy=0.
//  4. During conv WAIT, assert pool_done -> err_code=2.
//     Then start -> err clears and the program reruns from layer 0.
//  5. abort in WAIT of layer 1 -> IDLE next cycle; busy=0; no done.
//     A cfg_we issued earlier while busy is shown not applied on the rerun.
//  6. 8 CONV layers -> 8 en_conv pulses; cur_layer ends at 7 (no wrap);
//     done once; final bank=0.

Source files
------------

// File: rtl/layer_sched_if.sv
// Control and status bundle between the layer sequencer and its host/engines.
// The host side drives program/start/abort and the engines' done pulses; the sequencer drives the rest.
interface layer_sched_if #(
  parameter int IDX_W      = 3,
  parameter int ADDR_WIDTH = 18
);
  logic                  start;
  logic                  abort;
  logic                  cfg_we;
  logic [IDX_W-1:0]      cfg_idx;
  logic [1:0]            cfg_type;
  logic                  conv_done;
  logic                  pool_done;
  logic                  fc_done;
  logic                  en_conv;
  logic                  en_pool;
  logic                  en_fc;
  logic [1:0]            eng_sel;
  logic [ADDR_WIDTH-1:0] ifmap_base;
  logic [ADDR_WIDTH-1:0] ofmap_base;
  logic [IDX_W-1:0]      cur_layer;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [1:0]            err_code;

  modport master (
    output start, abort, cfg_we, cfg_idx, cfg_type, conv_done, pool_done, fc_done,
    input  en_conv, en_pool, en_fc, eng_sel, ifmap_base, ofmap_base, cur_layer,
           busy, done, err, err_code
  );

  modport slave (
    input  start, abort, cfg_we, cfg_idx, cfg_type, conv_done, pool_done, fc_done,
    output en_conv, en_pool, en_fc, eng_sel, ifmap_base, ofmap_base, cur_layer,
           busy, done, err, err_code
  );
endinterface

// File: rtl/layer_sched.sv
// Network-level sequencer: walks a small CONV/POOL/FC/END program, launches one engine per
// layer, steers the DRAM port, ping-pongs feature-map banks and watches for hung or stray engines.
module layer_sched #(
  parameter int                    NUM_LAYERS     = 8,
  parameter int                    IDX_W          = 3,
  parameter int                    ADDR_WIDTH     = 18,
  parameter logic [ADDR_WIDTH-1:0] BANK_A         = 18'd65536,
  parameter logic [ADDR_WIDTH-1:0] BANK_B         = 18'd131072,
  parameter int                    TIMEOUT_W      = 20,
  parameter logic [TIMEOUT_W-1:0]  TIMEOUT_CYCLES = 20'd1000000
) (
  input logic          clk,
  input logic          srstn,
  layer_sched_if.slave bus
);

  typedef enum logic [6:0] {
    S_IDLE   = 7'b0000001,
    S_FETCH  = 7'b0000010,
    S_LAUNCH = 7'b0000100,
    S_WAIT   = 7'b0001000,
    S_NEXT   = 7'b0010000,
    S_FINISH = 7'b0100000,
    S_ERROR  = 7'b1000000
  } state_t;

  typedef enum logic [1:0] {
    L_CONV = 2'd0,
    L_POOL = 2'd1,
    L_FC   = 2'd2,
    L_END  = 2'd3
  } layer_t;

  localparam logic [1:0]           SEL_NONE     = 2'd3;
  localparam logic [1:0]           ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0]           ERR_SPURIOUS = 2'd2;
  localparam logic [IDX_W-1:0]     LAST_IDX     = IDX_W'(NUM_LAYERS - 1);
  localparam logic [TIMEOUT_W-1:0] WD_LAST      = TIMEOUT_CYCLES - 1'b1;

  state_t               state;
  layer_t               tbl [NUM_LAYERS];
  logic [IDX_W-1:0]     cur_layer;
  logic                 bank;
  logic [TIMEOUT_W-1:0] watchdog;
  logic                 en_conv, en_pool, en_fc;
  logic [1:0]           eng_sel;
  logic                 busy, done, err;
  logic [1:0]           err_code;

  logic [2:0]           done_vec;
  logic [2:0]           sel_mask;
  logic                 sel_done;
  logic                 stray_done;

  // Program table: writable only while the sequencer is not running a program.
  always_ff @(posedge clk) begin
    if (!srstn) begin
      // NOTE: this table is reset entry by entry because an unprogrammed entry must read END;
      // a plain data RAM would normally be left without reset so it can map onto memory macros.
      for (int i = 0; i < NUM_LAYERS; i++) tbl[i] <= L_END;
    end else if (bus.cfg_we && !busy) begin
      tbl[bus.cfg_idx] <= layer_t'(bus.cfg_type);
    end
  end

  // Classify engine done pulses against the engine currently owning the DRAM port.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    done_vec   = {bus.fc_done, bus.pool_done, bus.conv_done};
    sel_mask   = 3'b001 << eng_sel;
    sel_done   = |(done_vec & sel_mask);
    stray_done = |(done_vec & ~sel_mask);
  end

  // NOTE: all state and outputs below update with <= so every branch sees the pre-edge values.
  always_ff @(posedge clk) begin
    if (!srstn) begin
      state     <= S_IDLE;
      cur_layer <= '0;
      bank      <= 1'b0;
      watchdog  <= '0;
      en_conv   <= 1'b0;
      en_pool   <= 1'b0;
      en_fc     <= 1'b0;
      eng_sel   <= SEL_NONE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= '0;
    end else if (bus.abort) begin
      state    <= S_IDLE;
      en_conv  <= 1'b0;
      en_pool  <= 1'b0;
      en_fc    <= 1'b0;
      eng_sel  <= SEL_NONE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= '0;
    end else begin
      // Launch and done strobes are single-cycle unless a branch re-asserts them.
      en_conv <= 1'b0;
      en_pool <= 1'b0;
      en_fc   <= 1'b0;
      done    <= 1'b0;
      unique case (state)
        S_IDLE, S_ERROR: begin
          if (bus.start) begin
            state     <= S_FETCH;
            cur_layer <= '0;
            bank      <= 1'b0;
            err       <= 1'b0;
            err_code  <= '0;
            busy      <= 1'b1;
          end
        end
        S_FETCH: begin
          if (tbl[cur_layer] == L_END) begin
            state <= S_FINISH;
            done  <= 1'b1;
          end else begin
            state <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          eng_sel  <= tbl[cur_layer];
          watchdog <= '0;
          en_conv  <= (tbl[cur_layer] == L_CONV);
          en_pool  <= (tbl[cur_layer] == L_POOL);
          en_fc    <= (tbl[cur_layer] == L_FC);
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (watchdog != '1) watchdog <= watchdog + 1'b1;
          // A stray done outranks a good one; a good done outranks the timeout.
          if (stray_done) begin
            state    <= S_ERROR;
            err      <= 1'b1;
            err_code <= ERR_SPURIOUS;
            eng_sel  <= SEL_NONE;
            busy     <= 1'b0;
          end else if (sel_done) begin
            state <= S_NEXT;
          end else if (watchdog == WD_LAST) begin
            state    <= S_ERROR;
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
            eng_sel  <= SEL_NONE;
            busy     <= 1'b0;
          end
        end
        S_NEXT: begin
          bank    <= ~bank;
          eng_sel <= SEL_NONE;
          if (cur_layer == LAST_IDX) begin
            state <= S_FINISH;
            done  <= 1'b1;
          end else begin
            cur_layer <= cur_layer + 1'b1;
            state     <= S_FETCH;
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= S_IDLE;
          eng_sel <= SEL_NONE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.en_conv    = en_conv;
  assign bus.en_pool    = en_pool;
  assign bus.en_fc      = en_fc;
  assign bus.eng_sel    = eng_sel;
  assign bus.ifmap_base = bank ? BANK_B : BANK_A;
  assign bus.ofmap_base = bank ? BANK_A : BANK_B;
  assign bus.cur_layer  = cur_layer;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.err        = err;
  assign bus.err_code   = err_code;

endmodule

// File: tb/tb_layer_sched.sv
// Bench for layer_sched: a launch-level program model plus directed scenarios
// (normal run, empty program, timeout, stray done, abort, full-depth program).
module tb_layer_sched;

  localparam int          NUM_LAYERS = 8;
  localparam int          IDX_W      = 3;
  localparam int          ADDR_WIDTH = 18;
  localparam logic [17:0] BANK_A     = 18'd65536;
  localparam logic [17:0] BANK_B     = 18'd131072;
  localparam logic [1:0]  T_CONV     = 2'd0;
  localparam logic [1:0]  T_POOL     = 2'd1;
  localparam logic [1:0]  T_FC       = 2'd2;
  localparam logic [1:0]  T_END      = 2'd3;
  localparam int          RESP_OK    = 0;
  localparam int          RESP_NONE  = 1;
  localparam int          RESP_WRONG = 2;

  logic clk = 1'b0;
  logic srstn = 1'b0;
  always #5 clk = ~clk;

  layer_sched_if #(.IDX_W(IDX_W), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  layer_sched #(
    .NUM_LAYERS(NUM_LAYERS), .IDX_W(IDX_W), .ADDR_WIDTH(ADDR_WIDTH),
    .BANK_A(BANK_A), .BANK_B(BANK_B), .TIMEOUT_W(20), .TIMEOUT_CYCLES(20'd16)
  ) dut (
    .clk(clk),
    .srstn(srstn),
    .bus(bus)
  );

  typedef struct {
    logic [1:0] typ;
    int         layer;
  } launch_t;

  int         checks = 0;
  int         errors = 0;
  logic [1:0] mtbl [NUM_LAYERS];
  bit         m_busy = 1'b0;
  launch_t    exp_q[$];
  int         exp_done = 0;
  int         launches_seen = 0;
  int         dones_seen = 0;
  bit         mon_en = 1'b0;
  int         resp_mode = RESP_OK;
  int         resp_delay = 10;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: layer i of a program runs with bank i%2 and stops at the first END or after the last entry.
  task automatic expect_run(input int max_layers, input bit completes);
    int i;
    i = 0;
    exp_q.delete();
    while (i < NUM_LAYERS && i < max_layers && mtbl[i] != T_END) begin
      exp_q.push_back('{typ: mtbl[i], layer: i});
      i++;
    end
    if (completes) exp_done++;
  endtask

  task automatic cfg_write(input int idx, input logic [1:0] typ);
    bus.cfg_we   = 1'b1;
    bus.cfg_idx  = IDX_W'(idx);
    bus.cfg_type = typ;
    if (!m_busy) mtbl[idx] = typ;
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle_reached"}, bus.busy, 0);
  endtask

  function automatic logic en_of(input logic [1:0] typ);
    case (typ)
      T_CONV:  return bus.en_conv;
      T_POOL:  return bus.en_pool;
      default: return bus.en_fc;
    endcase
  endfunction

  task automatic wait_en(input logic [1:0] typ, input string name);
    int n;
    n = 0;
    while (!en_of(typ) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({name, "_launch_seen"}, en_of(typ), 1);
  endtask

  task automatic run_ok(input string name);
    launches_seen = 0;
    dones_seen    = 0;
    resp_mode     = RESP_OK;
    resp_delay    = 10;
    expect_run(NUM_LAYERS, 1'b1);
    m_busy = 1'b1;
    pulse_start();
    check({name, "_started"}, bus.busy, 1);
    check({name, "_err_clear"}, bus.err, 0);
    wait_idle(name);
    m_busy = 1'b0;
    check({name, "_all_launched"}, exp_q.size(), 0);
    check({name, "_done_count"}, dones_seen, 1);
  endtask

  // Compare process: every launch is checked against the model; done and idle invariants every cycle.
  initial begin
    logic [2:0] ens;
    launch_t    e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        ens = {bus.en_fc, bus.en_pool, bus.en_conv};
        if (ens != 3'b000) begin
          launches_seen++;
          if (exp_q.size() == 0) begin
            check("unexpected_launch", ens, 0);
          end else begin
            e = exp_q.pop_front();
            check("launch_onehot", ens, 3'b001 << e.typ);
            check("launch_eng_sel", bus.eng_sel, e.typ);
            check("launch_layer", bus.cur_layer, e.layer);
            check("launch_ifmap", bus.ifmap_base, (e.layer % 2 == 1) ? BANK_B : BANK_A);
            check("launch_ofmap", bus.ofmap_base, (e.layer % 2 == 1) ? BANK_A : BANK_B);
            check("launch_busy", bus.busy, 1);
          end
        end
        if (bus.done) begin
          dones_seen++;
          check("done_expected", exp_done > 0, 1);
          if (exp_done > 0) exp_done--;
          check("done_after_all_layers", exp_q.size(), 0);
        end
        if (!bus.busy) begin
          check("idle_eng_sel", bus.eng_sel, 3);
          check("idle_no_launch", ens, 0);
        end
      end
    end
  end

  // Engine responder: answers each launch with a done after resp_delay cycles.
  initial begin
    logic [2:0] hit;
    bus.conv_done = 1'b0;
    bus.pool_done = 1'b0;
    bus.fc_done   = 1'b0;
    forever begin
      @(negedge clk);
      hit = {bus.en_fc, bus.en_pool, bus.en_conv};
      if (srstn && hit != 3'b000 && resp_mode != RESP_NONE) begin
        repeat (resp_delay) @(negedge clk);
        if (resp_mode == RESP_WRONG) begin
          if (hit[0]) bus.pool_done = 1'b1;
          else        bus.conv_done = 1'b1;
        end else begin
          bus.conv_done = hit[0];
          bus.pool_done = hit[1];
          bus.fc_done   = hit[2];
        end
        @(negedge clk);
        bus.conv_done = 1'b0;
        bus.pool_done = 1'b0;
        bus.fc_done   = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.cfg_we   = 1'b0;
    bus.cfg_idx  = '0;
    bus.cfg_type = '0;
    for (int i = 0; i < NUM_LAYERS; i++) mtbl[i] = T_END;

    // Reset values.
    srstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_en", {bus.en_fc, bus.en_pool, bus.en_conv}, 0);
    check("rst_eng_sel", bus.eng_sel, 3);
    check("rst_ifmap", bus.ifmap_base, BANK_A);
    check("rst_ofmap", bus.ofmap_base, BANK_B);
    check("rst_cur_layer", bus.cur_layer, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_err_code", bus.err_code, 0);
    srstn = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // 1: CONV, POOL, FC, END.
    cfg_write(0, T_CONV);
    cfg_write(1, T_POOL);
    cfg_write(2, T_FC);
    cfg_write(3, T_END);
    run_ok("t1");
    check("t1_launches", launches_seen, 3);
    check("t1_final_ifmap", bus.ifmap_base, BANK_B);
    check("t1_err", bus.err, 0);

    // 2: empty program, done two cycles after start.
    for (int i = 0; i < 4; i++) cfg_write(i, T_END);
    launches_seen = 0;
    dones_seen    = 0;
    expect_run(NUM_LAYERS, 1'b1);
    m_busy = 1'b1;
    pulse_start();
    check("t2_cycle1_done", bus.done, 0);
    check("t2_cycle1_busy", bus.busy, 1);
    @(negedge clk);
    check("t2_cycle2_done", bus.done, 1);
    @(negedge clk);
    check("t2_cycle3_done", bus.done, 0);
    check("t2_cycle3_busy", bus.busy, 0);
    m_busy = 1'b0;
    check("t2_launches", launches_seen, 0);
    check("t2_done_count", dones_seen, 1);
    check("t2_bank", bus.ifmap_base, BANK_A);

    // 3: hung conv engine, watchdog of 16 cycles.
    cfg_write(0, T_CONV);
    resp_mode     = RESP_NONE;
    launches_seen = 0;
    dones_seen    = 0;
    expect_run(1, 1'b0);
    m_busy = 1'b1;
    pulse_start();
    wait_en(T_CONV, "t3");
    n = 0;
    while (!bus.err && n < 100) begin
      @(negedge clk);
      n++;
    end
    m_busy = 1'b0;
    check("t3_timeout_cycles", n, 16);
    check("t3_err", bus.err, 1);
    check("t3_err_code", bus.err_code, 1);
    check("t3_eng_sel", bus.eng_sel, 3);
    check("t3_busy", bus.busy, 0);
    check("t3_no_done", dones_seen, 0);

    // 4: stray pool_done during conv WAIT, then restart from ERROR.
    cfg_write(1, T_POOL);
    cfg_write(2, T_FC);
    resp_mode     = RESP_WRONG;
    resp_delay    = 3;
    launches_seen = 0;
    dones_seen    = 0;
    expect_run(1, 1'b0);
    m_busy = 1'b1;
    pulse_start();
    wait_idle("t4");
    m_busy = 1'b0;
    check("t4_err", bus.err, 1);
    check("t4_err_code", bus.err_code, 2);
    check("t4_eng_sel", bus.eng_sel, 3);
    check("t4_no_done", dones_seen, 0);
    repeat (5) @(negedge clk);
    run_ok("t4_rerun");
    check("t4_rerun_launches", launches_seen, 3);
    check("t4_rerun_err_code", bus.err_code, 0);

    // 5: write while busy is dropped; abort in layer 1 WAIT.
    launches_seen = 0;
    dones_seen    = 0;
    expect_run(NUM_LAYERS, 1'b0);
    m_busy = 1'b1;
    pulse_start();
    cfg_write(1, T_END);
    wait_en(T_POOL, "t5");
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    exp_q.delete();
    m_busy = 1'b0;
    check("t5_abort_busy", bus.busy, 0);
    check("t5_abort_en", {bus.en_fc, bus.en_pool, bus.en_conv}, 0);
    check("t5_abort_eng_sel", bus.eng_sel, 3);
    check("t5_abort_done", bus.done, 0);
    repeat (20) @(negedge clk);
    check("t5_still_idle", bus.busy, 0);
    check("t5_no_done", dones_seen, 0);
    run_ok("t5_rerun");
    check("t5_rerun_launches", launches_seen, 3);

    // 6: eight CONV layers, no index wrap.
    for (int i = 0; i < NUM_LAYERS; i++) cfg_write(i, T_CONV);
    run_ok("t6");
    check("t6_launches", launches_seen, 8);
    check("t6_cur_layer", bus.cur_layer, 7);
    check("t6_final_ifmap", bus.ifmap_base, BANK_A);
    check("t6_final_ofmap", bus.ofmap_base, BANK_B);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
